// File: rtl/level_progression_ctrl.sv
// Game-flow controller: score, lives, game state and per-lane direction pattern for the movement stage.
// Optional build macro REVERSE_LFSR_EN selects an LFSR-derived lane pattern instead of alternate/complement.
module level_progression_ctrl #(
    parameter int         NUM_BITS      = 4,
    parameter int         MAX_SCORE     = 15,
    parameter int         START_LIVES   = 3,
    parameter int         INVULN_CYCLES = 25000000,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    input  logic                i_Start,
    input  logic                i_Goal_Reached,
    input  logic                i_Collision,
    output logic [3:0]          o_Score,
    output logic [1:0]          o_Lives,
    output logic                o_Level_Up,
    output logic [NUM_BITS-1:0] o_Reverse,
    output logic                o_Frog_Reset,
    output logic                o_Game_Active,
    output logic                o_Game_Over
);

    // state     | meaning
    // S_IDLE    | waiting for first start, outputs idle
    // S_PLAY    | game running, accepting goal/collision pulses
    // S_LEVEL_UP| one-cycle strobe, new lane pattern presented
    // S_HIT     | invulnerability window after losing a life
    // S_GAME_OVER| no lives left, score held until restart
    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_LEVEL_UP,
        S_HIT,
        S_GAME_OVER
    } state_t;

    localparam int                  CNT_W    = $clog2(INVULN_CYCLES + 1);
    localparam logic [CNT_W-1:0]    HIT_LAST = CNT_W'(INVULN_CYCLES - 1);
    localparam logic [3:0]          SCORE_MAX = 4'(MAX_SCORE);
    localparam logic [1:0]          LIVES_INIT = 2'(START_LIVES);

    // Downstream reads an all-zero pattern as "not loaded", so never present one.
    function automatic logic [NUM_BITS-1:0] zero_guard(input logic [NUM_BITS-1:0] p);
        return (p == '0) ? NUM_BITS'(1) : p;
    endfunction

    state_t             state;
    logic [CNT_W-1:0]   hit_cnt;
    logic [NUM_BITS-1:0] start_pattern;
    logic [NUM_BITS-1:0] goal_pattern;

`ifdef REVERSE_LFSR_EN
    logic [7:0] lfsr;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
        end
    end

    assign start_pattern = zero_guard(lfsr[NUM_BITS-1:0]);
    assign goal_pattern  = zero_guard(lfsr[NUM_BITS-1:0]);
`else
    function automatic logic [NUM_BITS-1:0] alt_pattern();
        logic [NUM_BITS-1:0] p;
        for (int i = 0; i < NUM_BITS; i++) begin
            p[i] = (i % 2 == 0);
        end
        return p;
    endfunction

    localparam logic [NUM_BITS-1:0] ALT_PATTERN = alt_pattern();

    assign start_pattern = ALT_PATTERN;
    assign goal_pattern  = zero_guard(~o_Reverse);

    // Seed only matters for the LFSR build; an all-zero seed would lock the LFSR.
    if (LFSR_SEED == 8'h00) begin : g_lfsr_seed_zero_unsupported
    end
`endif

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state         <= S_IDLE;
            hit_cnt       <= '0;
            o_Score       <= '0;
            o_Lives       <= LIVES_INIT;
            o_Reverse     <= '0;
            o_Level_Up    <= 1'b0;
            o_Frog_Reset  <= 1'b0;
            o_Game_Active <= 1'b0;
            o_Game_Over   <= 1'b0;
        end else begin
            o_Level_Up   <= 1'b0;
            o_Frog_Reset <= 1'b0;
            case (state)
                S_IDLE, S_GAME_OVER: begin
                    if (i_Start) begin
                        state         <= S_LEVEL_UP;
                        o_Score       <= '0;
                        o_Lives       <= LIVES_INIT;
                        o_Reverse     <= start_pattern;
                        o_Level_Up    <= 1'b1;
                        o_Frog_Reset  <= 1'b1;
                        o_Game_Active <= 1'b1;
                        o_Game_Over   <= 1'b0;
                    end
                end
                S_PLAY: begin
                    if (i_Collision) begin
                        if (o_Lives <= 2'd1) begin
                            state         <= S_GAME_OVER;
                            o_Lives       <= 2'd0;
                            o_Game_Active <= 1'b0;
                            o_Game_Over   <= 1'b1;
                        end else begin
                            state        <= S_HIT;
                            hit_cnt      <= '0;
                            o_Lives      <= o_Lives - 2'd1;
                            o_Frog_Reset <= 1'b1;
                        end
                    end else if (i_Goal_Reached) begin
                        state        <= S_LEVEL_UP;
                        o_Score      <= (o_Score == SCORE_MAX) ? SCORE_MAX : o_Score + 4'd1;
                        o_Reverse    <= goal_pattern;
                        o_Level_Up   <= 1'b1;
                        o_Frog_Reset <= 1'b1;
                    end
                end
                S_LEVEL_UP: begin
                    state <= S_PLAY;
                end
                S_HIT: begin
                    if (hit_cnt == HIT_LAST) begin
                        state   <= S_PLAY;
                        hit_cnt <= '0;
                    end else begin
                        hit_cnt <= hit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_level_progression_ctrl.sv
// Directed self-checking bench for level_progression_ctrl with an 8-cycle invulnerability window.
module tb_level_progression_ctrl;

    logic       i_Clk = 1'b0;
    logic       i_Rst_L = 1'b0;
    logic       i_Start = 1'b0;
    logic       i_Goal_Reached = 1'b0;
    logic       i_Collision = 1'b0;
    logic [3:0] o_Score;
    logic [1:0] o_Lives;
    logic       o_Level_Up;
    logic [3:0] o_Reverse;
    logic       o_Frog_Reset;
    logic       o_Game_Active;
    logic       o_Game_Over;

    int total = 0;
    int bad = 0;
    logic [3:0] exp_rev;
    logic [3:0] exp_score;

    level_progression_ctrl #(
        .NUM_BITS(4), .MAX_SCORE(15), .START_LIVES(3), .INVULN_CYCLES(8), .LFSR_SEED(8'hA5)
    ) dut (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Start(i_Start),
        .i_Goal_Reached(i_Goal_Reached), .i_Collision(i_Collision),
        .o_Score(o_Score), .o_Lives(o_Lives), .o_Level_Up(o_Level_Up),
        .o_Reverse(o_Reverse), .o_Frog_Reset(o_Frog_Reset),
        .o_Game_Active(o_Game_Active), .o_Game_Over(o_Game_Over)
    );

    always #5 i_Clk = ~i_Clk;

    // Inputs change on falling edges; each pulse is sampled by exactly one rising edge,
    // and the task returns on the falling edge right after it, i.e. in the response cycle.
    task automatic drive_at(input int waits, input logic s, input logic g, input logic c);
        repeat (waits) @(negedge i_Clk);
        i_Start = s; i_Goal_Reached = g; i_Collision = c;
        @(negedge i_Clk);
        i_Start = 1'b0; i_Goal_Reached = 1'b0; i_Collision = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge i_Clk);
        i_Rst_L = 1'b0;
        repeat (2) @(negedge i_Clk);
        i_Rst_L = 1'b1;
        @(negedge i_Clk);
    endtask

    task automatic test_reset();
        i_Rst_L = 1'b0;
        repeat (2) @(negedge i_Clk);
        #1;
        total++; if (o_Score !== 4'd0) begin bad++; $display("FAIL reset_score got=%0d exp=0", o_Score); end
        total++; if (o_Lives !== 2'd3) begin bad++; $display("FAIL reset_lives got=%0d exp=3", o_Lives); end
        total++; if (o_Reverse !== 4'b0000) begin bad++; $display("FAIL reset_reverse got=%b exp=0000", o_Reverse); end
        total++; if ({o_Level_Up, o_Frog_Reset, o_Game_Active, o_Game_Over} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b exp=0000", {o_Level_Up, o_Frog_Reset, o_Game_Active, o_Game_Over});
        end
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
        repeat (2) @(negedge i_Clk);
        total++; if ({o_Level_Up, o_Game_Active} !== 2'b00) begin
            bad++; $display("FAIL idle_hold got=%b exp=00", {o_Level_Up, o_Game_Active});
        end
    endtask

    task automatic test_start();
        drive_at(1, 1'b1, 1'b0, 1'b0);
        total++; if (o_Level_Up !== 1'b1) begin bad++; $display("FAIL start_level_up got=%b exp=1", o_Level_Up); end
        total++; if (o_Frog_Reset !== 1'b1) begin bad++; $display("FAIL start_frog_reset got=%b exp=1", o_Frog_Reset); end
        total++; if (o_Reverse !== 4'b0101) begin bad++; $display("FAIL start_reverse got=%b exp=0101", o_Reverse); end
        total++; if (o_Score !== 4'd0) begin bad++; $display("FAIL start_score got=%0d exp=0", o_Score); end
        total++; if (o_Lives !== 2'd3) begin bad++; $display("FAIL start_lives got=%0d exp=3", o_Lives); end
        total++; if ({o_Game_Active, o_Game_Over} !== 2'b10) begin
            bad++; $display("FAIL start_active got=%b exp=10", {o_Game_Active, o_Game_Over});
        end
        @(negedge i_Clk);
        total++; if ({o_Level_Up, o_Frog_Reset} !== 2'b00) begin
            bad++; $display("FAIL start_strobe_width got=%b exp=00", {o_Level_Up, o_Frog_Reset});
        end
        total++; if (o_Reverse !== 4'b0101) begin bad++; $display("FAIL start_reverse_hold got=%b exp=0101", o_Reverse); end
        exp_rev = 4'b0101;
    endtask

    task automatic test_start_ignored();
        drive_at(1, 1'b1, 1'b0, 1'b0);
        total++; if ({o_Level_Up, o_Frog_Reset} !== 2'b00) begin
            bad++; $display("FAIL start_in_play got=%b exp=00", {o_Level_Up, o_Frog_Reset});
        end
        total++; if (o_Reverse !== exp_rev) begin bad++; $display("FAIL start_in_play_rev got=%b exp=%b", o_Reverse, exp_rev); end
    endtask

    task automatic test_goals();
        for (int k = 1; k <= 3; k++) begin
            exp_rev = ~exp_rev;
            drive_at(1, 1'b0, 1'b1, 1'b0);
            total++; if (o_Score !== 4'(k)) begin bad++; $display("FAIL goal_score got=%0d exp=%0d", o_Score, k); end
            total++; if (o_Reverse !== exp_rev) begin bad++; $display("FAIL goal_reverse got=%b exp=%b", o_Reverse, exp_rev); end
            total++; if ({o_Level_Up, o_Frog_Reset} !== 2'b11) begin
                bad++; $display("FAIL goal_strobe got=%b exp=11", {o_Level_Up, o_Frog_Reset});
            end
            @(negedge i_Clk);
            total++; if (o_Level_Up !== 1'b0) begin bad++; $display("FAIL goal_strobe_width got=%b exp=0", o_Level_Up); end
        end
    endtask

    task automatic test_score_saturate();
        for (int k = 4; k <= 16; k++) begin
            exp_score = (k > 15) ? 4'd15 : 4'(k);
            exp_rev = ~exp_rev;
            drive_at(1, 1'b0, 1'b1, 1'b0);
            total++; if (o_Score !== exp_score) begin bad++; $display("FAIL sat_score got=%0d exp=%0d", o_Score, exp_score); end
            total++; if (o_Reverse !== exp_rev) begin bad++; $display("FAIL sat_reverse got=%b exp=%b", o_Reverse, exp_rev); end
            total++; if (o_Level_Up !== 1'b1) begin bad++; $display("FAIL sat_level_up got=%b exp=1", o_Level_Up); end
        end
    endtask

    task automatic test_collision_priority();
        drive_at(1, 1'b0, 1'b1, 1'b1);
        total++; if (o_Lives !== 2'd2) begin bad++; $display("FAIL prio_lives got=%0d exp=2", o_Lives); end
        total++; if (o_Score !== 4'd15) begin bad++; $display("FAIL prio_score got=%0d exp=15", o_Score); end
        total++; if ({o_Level_Up, o_Frog_Reset} !== 2'b01) begin
            bad++; $display("FAIL prio_strobe got=%b exp=01", {o_Level_Up, o_Frog_Reset});
        end
        total++; if (o_Reverse !== exp_rev) begin bad++; $display("FAIL prio_reverse got=%b exp=%b", o_Reverse, exp_rev); end
        @(negedge i_Clk);
        total++; if (o_Frog_Reset !== 1'b0) begin bad++; $display("FAIL hit_frog_width got=%b exp=0", o_Frog_Reset); end
        drive_at(1, 1'b0, 1'b1, 1'b1);
        total++; if (o_Lives !== 2'd2) begin bad++; $display("FAIL hit_ignore_early got=%0d exp=2", o_Lives); end
        total++; if (o_Level_Up !== 1'b0) begin bad++; $display("FAIL hit_goal_ignored got=%b exp=0", o_Level_Up); end
        drive_at(4, 1'b0, 1'b0, 1'b1);
        total++; if (o_Lives !== 2'd2) begin bad++; $display("FAIL hit_ignore_last got=%0d exp=2", o_Lives); end
        drive_at(0, 1'b0, 1'b0, 1'b1);
        total++; if (o_Lives !== 2'd1) begin bad++; $display("FAIL hit_window_end got=%0d exp=1", o_Lives); end
        total++; if (o_Frog_Reset !== 1'b1) begin bad++; $display("FAIL hit2_frog got=%b exp=1", o_Frog_Reset); end
    endtask

    task automatic test_game_over();
        do_reset();
        drive_at(1, 1'b1, 1'b0, 1'b0);
        drive_at(1, 1'b0, 1'b1, 1'b0);
        total++; if (o_Score !== 4'd1) begin bad++; $display("FAIL go_prep_score got=%0d exp=1", o_Score); end
        drive_at(1, 1'b0, 1'b0, 1'b1);
        total++; if (o_Lives !== 2'd2) begin bad++; $display("FAIL go_lives_a got=%0d exp=2", o_Lives); end
        drive_at(9, 1'b0, 1'b0, 1'b1);
        total++; if (o_Lives !== 2'd1) begin bad++; $display("FAIL go_lives_b got=%0d exp=1", o_Lives); end
        drive_at(9, 1'b0, 1'b0, 1'b1);
        total++; if (o_Lives !== 2'd0) begin bad++; $display("FAIL go_lives_c got=%0d exp=0", o_Lives); end
        total++; if ({o_Game_Over, o_Game_Active, o_Frog_Reset} !== 3'b100) begin
            bad++; $display("FAIL go_flags got=%b exp=100", {o_Game_Over, o_Game_Active, o_Frog_Reset});
        end
        drive_at(2, 1'b0, 1'b1, 1'b1);
        total++; if ({o_Score, o_Lives, o_Level_Up, o_Game_Over} !== {4'd1, 2'd0, 1'b0, 1'b1}) begin
            bad++; $display("FAIL go_hold got=%h exp=%h", {o_Score, o_Lives, o_Level_Up, o_Game_Over}, {4'd1, 2'd0, 1'b0, 1'b1});
        end
        drive_at(1, 1'b1, 1'b0, 1'b0);
        total++; if (o_Lives !== 2'd3) begin bad++; $display("FAIL restart_lives got=%0d exp=3", o_Lives); end
        total++; if (o_Score !== 4'd0) begin bad++; $display("FAIL restart_score got=%0d exp=0", o_Score); end
        total++; if ({o_Level_Up, o_Game_Active, o_Game_Over} !== 3'b110) begin
            bad++; $display("FAIL restart_flags got=%b exp=110", {o_Level_Up, o_Game_Active, o_Game_Over});
        end
        total++; if (o_Reverse !== 4'b0101) begin bad++; $display("FAIL restart_reverse got=%b exp=0101", o_Reverse); end
    endtask

    task automatic test_reset_mid_hit();
        drive_at(1, 1'b0, 1'b0, 1'b1);
        total++; if (o_Lives !== 2'd2) begin bad++; $display("FAIL midhit_prep got=%0d exp=2", o_Lives); end
        repeat (3) @(negedge i_Clk);
        #2 i_Rst_L = 1'b0;
        #1;
        total++; if ({o_Score, o_Lives, o_Reverse} !== {4'd0, 2'd3, 4'b0000}) begin
            bad++; $display("FAIL midhit_regs got=%h exp=%h", {o_Score, o_Lives, o_Reverse}, {4'd0, 2'd3, 4'b0000});
        end
        total++; if ({o_Level_Up, o_Frog_Reset, o_Game_Active, o_Game_Over} !== 4'b0000) begin
            bad++; $display("FAIL midhit_flags got=%b exp=0000", {o_Level_Up, o_Frog_Reset, o_Game_Active, o_Game_Over});
        end
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
        repeat (10) @(negedge i_Clk);
        total++; if ({o_Frog_Reset, o_Game_Active, o_Lives} !== {1'b0, 1'b0, 2'd3}) begin
            bad++; $display("FAIL midhit_no_pending got=%b exp=%b", {o_Frog_Reset, o_Game_Active, o_Lives}, {1'b0, 1'b0, 2'd3});
        end
        drive_at(1, 1'b1, 1'b0, 1'b0);
        total++; if ({o_Level_Up, o_Reverse} !== {1'b1, 4'b0101}) begin
            bad++; $display("FAIL midhit_restart got=%b exp=%b", {o_Level_Up, o_Reverse}, {1'b1, 4'b0101});
        end
    endtask

`ifdef REVERSE_LFSR_EN
    task automatic test_lfsr();
        do_reset();
        drive_at(1, 1'b1, 1'b0, 1'b0);
        total++; if (o_Reverse === 4'b0000) begin bad++; $display("FAIL lfsr_start got=%b exp=nonzero", o_Reverse); end
        for (int n = 0; n < 1000; n++) begin
            drive_at(int'($urandom_range(1, 4)), 1'b0, 1'b1, 1'b0);
            total++; if (o_Level_Up !== 1'b1 || o_Reverse === 4'b0000) begin
                bad++; $display("FAIL lfsr_level_up got=%b/%b exp=1/nonzero", o_Level_Up, o_Reverse);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef REVERSE_LFSR_EN
        test_lfsr();
`else
        test_start();
        test_start_ignored();
        test_goals();
        test_score_saturate();
        test_collision_priority();
        test_game_over();
        test_reset_mid_hit();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
